// File: rtl/seg7_scan_if.sv
// Digit descriptor inputs and multiplexed anode/cathode outputs of the
// eight-digit 7-segment scan driver.
interface seg7_scan_if;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic [7:0] an;
    logic [7:0] dec_cat;

    modport master (
        output d1, d2, d3, d4, d5, d6, d7, d8,
        input  an, dec_cat
    );

    modport slave (
        input  d1, d2, d3, d4, d5, d6, d7, d8,
        output an, dec_cat
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed eight-digit 7-segment driver: prescaled scan, per-frame
// descriptor snapshot, hex-to-segment decode and a registered output stage.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic   clk,
    input  logic   rst,
    seg7_scan_if.slave bus
);
    localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    typedef struct packed {
        logic       en;
        logic [3:0] hex;
        logic       dp;
    } digit_t;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    digit_t        shadow [8];
    logic          tick;
    digit_t        cur;
    logic [7:0]    seg_bits;
    logic [7:0]    an_nxt;
    logic [7:0]    cat_nxt;

    // Active-low {a..g,dp} patterns with the decimal point off.
    function automatic logic [7:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 8'h03;  4'h1: seg7 = 8'h9F;
            4'h2: seg7 = 8'h25;  4'h3: seg7 = 8'h0D;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h49;
            4'h6: seg7 = 8'h41;  4'h7: seg7 = 8'h1F;
            4'h8: seg7 = 8'h01;  4'h9: seg7 = 8'h09;
            4'hA: seg7 = 8'h11;  4'hB: seg7 = 8'hC1;
            4'hC: seg7 = 8'h63;  4'hD: seg7 = 8'h85;
            4'hE: seg7 = 8'h61;  default: seg7 = 8'h71;
        endcase
    endfunction

    assign tick = (cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            // NOTE: the shadow file is reset deliberately: a cleared descriptor
            // means "disabled", which keeps the display blank until the first frame.
            for (int k = 0; k < 8; k++) shadow[k] <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                idx <= idx + 3'd1;
                // Snapshot on the 7->0 wrap so a frame never mixes old and new digits.
                if (idx == 3'd7) begin
                    shadow[0] <= bus.d1;
                    shadow[1] <= bus.d2;
                    shadow[2] <= bus.d3;
                    shadow[3] <= bus.d4;
                    shadow[4] <= bus.d5;
                    shadow[5] <= bus.d6;
                    shadow[6] <= bus.d7;
                    shadow[7] <= bus.d8;
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block can infer a latch.
    always_comb begin
        cur      = shadow[idx];
        seg_bits = seg7(cur.hex);
        an_nxt   = 8'hFF;
        cat_nxt  = 8'hFF;
        if (cur.en) begin
            an_nxt  = ~(8'h01 << idx);
            cat_nxt = {seg_bits[7:1], ~cur.dp};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.an      <= 8'hFF;
            bus.dec_cat <= 8'hFF;
        end else begin
            bus.an      <= an_nxt;
            bus.dec_cat <= cat_nxt;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a cycle-level scoreboard derived
// from frame timing, a decode vector table and hand-written corner sequences.
module tb_seg7_scan_driver;
    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] tb_d [8];

    int checks = 0;
    int errors = 0;

    logic [7:0] seg_ref [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    seg7_scan_if bus ();

    assign bus.d1 = tb_d[0];
    assign bus.d2 = tb_d[1];
    assign bus.d3 = tb_d[2];
    assign bus.d4 = tb_d[3];
    assign bus.d5 = tb_d[4];
    assign bus.d6 = tb_d[5];
    assign bus.d7 = tb_d[6];
    assign bus.d8 = tb_d[7];

    seg7_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output per edge, from elapsed cycles since reset and a
    // frame-aligned copy of the inputs.
    logic [15:0] sb_q [$];
    logic [5:0]  sh_m [8];
    int          t_m = 0;

    always @(posedge clk) begin
        logic [15:0] e;
        int          slot;
        e = 16'hFFFF;
        if (rst) begin
            t_m = 0;
            for (int k = 0; k < 8; k++) sh_m[k] = '0;
        end else begin
            t_m++;
            slot = ((t_m - 1) % FRAME) / SD;
            if (sh_m[slot][5]) begin
                e[15:8] = ~(8'h01 << slot);
                e[7:0]  = {seg_ref[sh_m[slot][4:1]][7:1], ~sh_m[slot][0]};
            end
            if (t_m % FRAME == 0)
                for (int k = 0; k < 8; k++) sh_m[k] = tb_d[k];
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
        end else begin
            check("scoreboard", {bus.an, bus.dec_cat}, sb_q.pop_front());
        end
    end

    task automatic wait_an(input logic [7:0] v, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.an !== v && n < 200);
        if (bus.an !== v) check({name, "_timeout"}, {8'h00, bus.an}, {8'h00, v});
    endtask

    task automatic check_blank_run(input int cycles, input string name);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.an !== 8'hFF || bus.dec_cat !== 8'hFF) bad++;
        end
        check(name, 16'(bad), 16'd0);
    endtask

    typedef struct {
        logic [5:0] d1;
        logic [7:0] cat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{{1'b1, 4'hF, 1'b1}, 8'h70};
        vecs[1] = '{{1'b1, 4'h8, 1'b1}, 8'h00};
        vecs[2] = '{{1'b1, 4'hA, 1'b0}, 8'h11};
        vecs[3] = '{{1'b1, 4'h0, 1'b0}, 8'h03};
        vecs[4] = '{{1'b1, 4'h5, 1'b0}, 8'h49};
        vecs[5] = '{{1'b1, 4'hB, 1'b0}, 8'hC1};
        vecs[6] = '{{1'b1, 4'hD, 1'b1}, 8'h84};
        vecs[7] = '{{1'b1, 4'hC, 1'b1}, 8'h62};

        for (int k = 0; k < 8; k++) tb_d[k] = {1'b1, 4'(k), 1'b0};

        // Reset with live inputs, then blank until the first snapshot.
        repeat (3) @(negedge clk);
        check("reset_an_cat", {bus.an, bus.dec_cat}, 16'hFFFF);
        rst = 1'b0;
        check_blank_run(FRAME, "blank_before_snapshot");

        // Scan order across one full frame.
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            check("scan_an", {8'h00, bus.an}, {8'h00, ~(8'h01 << (i / SD))});
            if (i == 0)          check("scan_cat_d1", {8'h00, bus.dec_cat}, 16'h0003);
            if (i == SD)         check("scan_cat_d2", {8'h00, bus.dec_cat}, 16'h009F);
            if (i == FRAME - SD) check("scan_cat_d8", {8'h00, bus.dec_cat}, 16'h001F);
        end

        // Blank slot 2; neighbours and frame length unaffected.
        wait_an(8'h7F, "blank_sync");
        tb_d[2][5] = 1'b0;
        wait_an(8'hFE, "blank_frame");
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (i / SD == 2) check("blank_slot", {bus.an, bus.dec_cat}, 16'hFFFF);
            else check("blank_neighbour_an", {8'h00, bus.an}, {8'h00, ~(8'h01 << (i / SD))});
        end
        @(negedge clk);
        check("blank_frame_len", {8'h00, bus.an}, 16'h00FE);

        // Frame coherence: d5 changes mid-frame, shown only from the next frame.
        tb_d[2][5] = 1'b1;
        wait_an(8'h7F, "coh_sync");
        tb_d[4] = {1'b1, 4'h2, 1'b0};
        wait_an(8'hFE, "coh_frame");
        wait_an(8'hF7, "coh_idx3");
        tb_d[4] = {1'b1, 4'h7, 1'b0};
        wait_an(8'hEF, "coh_slot4_old");
        check("coh_same_frame", {8'h00, bus.dec_cat}, 16'h0025);
        wait_an(8'hFE, "coh_next");
        wait_an(8'hEF, "coh_slot4_new");
        check("coh_next_frame", {8'h00, bus.dec_cat}, 16'h001F);

        // Decode table through digit 1, each loaded just before a snapshot.
        for (int v = 0; v < 8; v++) begin
            wait_an(8'h7F, "vec_sync");
            tb_d[0] = vecs[v].d1;
            wait_an(8'hFE, "vec_show");
            check($sformatf("decode_vec%0d", v), {8'h00, bus.dec_cat}, {8'h00, vecs[v].cat});
        end

        // Reset mid-scan while slot 5 is lit.
        wait_an(8'hDF, "midrst_sync");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out", {bus.an, bus.dec_cat}, 16'hFFFF);
        rst = 1'b0;
        check_blank_run(FRAME, "midrst_blank");
        @(negedge clk);
        check("midrst_first_digit", {8'h00, bus.an}, 16'h00FE);

        // All digits disabled: anodes stay off once the old frame drains.
        for (int k = 0; k < 8; k++) tb_d[k][5] = 1'b0;
        repeat (FRAME + 8) @(negedge clk);
        check_blank_run(2 * FRAME, "all_disabled");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
